audio_fetch_scheduler: RTL and testbench
========================================

# audio_fetch_scheduler

Time-multiplexes the single-port audio sample ROM between three playback channels: background music (BGM) and two sound-effect voices (SFX0 = hit, SFX1 = miss). On every 44.1 kHz sample tick it issues one ROM read per active channel in fixed order. It captures the returned samples and outputs a saturated signed mix. It sits between the rhythm/game control logic, which supplies start/stop/trigger pulses, and the audio DAC path, which consumes `mix_out`.

## Interface
- `ADDR_W`, 18, ROM address width
- `DATA_W`, 16, signed sample width (fixed at 16 for the saturation rules below)
- `BGM_BASE`, 0, BGM first ROM address
- `BGM_LEN`, 176400, BGM length in samples
- `SFX0_BASE`, 176400, SFX0 first address
- `SFX0_LEN`, 4410, SFX0 length
- `SFX1_BASE`, 180810, SFX1 first address
- `SFX1_LEN`, 4410, SFX1 length

- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `sample_tick`  in  1  one-cycle strobe at the sample rate
- `bgm_start`  in  1  pulse; start BGM from sample 0, or restart it if already playing
- `bgm_stop`  in  1  pulse; stop BGM
- `sfx_trig`  in  2  per-voice pulse; start the voice from 0, or restart it
- `overrun_clr`  in  1  clears `overrun`
- `rom_en`  out  1  ROM read enable (registered)
- `rom_addr`  out  ADDR_W  ROM read address (registered)
- `rom_data`  in  DATA_W  ROM read data, valid the cycle after `rom_en`
- `mix_out`  out  16  signed saturated mix
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates
- `bgm_playing`  out  1  BGM channel active
- `bgm_pos`  out  ADDR_W  BGM sample index of the next fetch
- `sfx_active`  out  2  per-voice active flags
- `bgm_done`  out  1  one-cycle pulse when BGM plays its last sample
- `overrun`  out  1  sticky flag: a tick was dropped

## Operation
- **States:** IDLE → ISSUE → DRAIN → MIX → IDLE.
- **Control pulses** (`bgm_start`, `bgm_stop`, `sfx_trig`) are latched into pending-request flags at any cycle. They are applied only on a clock edge where the state is IDLE.
  - Start/trigger: set the channel active and zero its pointer.
  - Stop: clear BGM active.
  - `bgm_start` and `bgm_stop` in the same cycle: stop wins.
- **Tick in IDLE:**
  - Pending control flags are applied first, then the fetch mask {BGM, SFX0, SFX1} is latched from the updated active flags.
  - The sample register of every channel not in the mask is cleared to 0.
  - Next state is ISSUE if the mask is non-zero, otherwise DRAIN.
- **ISSUE:**
  - Each cycle, issue the lowest-index pending channel (order BGM, SFX0, SFX1): `rom_en` = 1, `rom_addr` = base + pointer.
  - Clear that channel's mask bit and increment its pointer.
  - Record a 2-bit tag in a one-stage tag pipeline.
  - Move to DRAIN after the last issue.
- **Data capture:** `rom_data` is captured into the tagged channel's sample register on the cycle after each issue.
- **End of channel:** the issue of pointer = LEN−1 clears the channel's active flag on the same edge.
  - For BGM, `bgm_done` pulses in the following cycle.
  - That final sample is still captured and mixed in the current frame.
- **DRAIN:** one cycle, to capture the last data; `rom_en` = 0.
- **MIX:**
  - Sum the three 16-bit signed samples in 18 bits.
  - Saturate to the range [−32768, 32767].
  - Register `mix_out` and pulse `mix_valid`.
- **Tick while not IDLE:** the tick is dropped, `overrun` is set, and the sequence is unaffected. `overrun` stays set until `overrun_clr`. If a tick and `overrun_clr` arrive together, set wins.
- **Reset** (asynchronous, at any point including mid-ISSUE):
  - All outputs, pointers, mask and pending flags go to 0.
  - State goes to IDLE.
  - `rom_en` drops immediately.

## Timing
- Let the tick be sampled in cycle T and let n = number of active channels (0–3).
- `rom_en` is high in cycles T+1 … T+n with consecutive issues; there are no idle gaps.
- State is DRAIN in cycle T+n+1 and MIX in cycle T+n+2.
- `mix_out` and `mix_valid` are visible in cycle T+n+3; the state is back in IDLE in that same cycle.
- A tick in cycle T+n+3 or later is accepted.
- A tick in cycles T+1 … T+n+2 is counted as an overrun.
- Worst-case busy time is 5 cycles; the system clock must exceed 6× the sample rate.
- Reset value of every output is 0, including `mix_out` = 0x0000.

## Test plan
- **Reset and idle ticks:** assert `rst_n` = 0, then release; tick with no channel active → all outputs 0, `rom_en` never high, `mix_valid` pulses at T+3 with `mix_out` = 0.
- **BGM end of playback:** BGM_LEN = 4, ROM model data = address, `bgm_start`, then ticks every 10 cycles.
  - `rom_addr` sequence is 0, 1, 2, 3.
  - `mix_out` sequence is 0, 1, 2, 3.
  - `bgm_done` pulses the cycle after address 3 is issued; `bgm_playing` = 0 from then on.
  - The 5th tick gives no `rom_en` and `mix_out` = 0.
- **All three channels active:** `rom_addr` = BGM_BASE+p, SFX0_BASE, SFX1_BASE in cycles T+1, T+2, T+3; `mix_valid` at T+6.
- **Saturation:** BGM = 30000, SFX0 = 30000 → `mix_out` = 32767; BGM = −30000, SFX0 = −30000 → `mix_out` = −32768; BGM = 100, SFX0 = −300, SFX1 = 50 → `mix_out` = −150.
- **Overrun:** with 2 channels active, a tick at T+2 → `overrun` = 1, no extra fetch, `mix_valid` only at T+5. `overrun_clr` → `overrun` = 0.
- **Restart and reset:**
  - `sfx_trig[0]` in the same cycle as a tick, with SFX0 at pointer 5 → fetch address is SFX0_BASE+0.
  - `rst_n` low during ISSUE → `rom_en` = 0 with no clock edge needed; no `mix_valid` afterwards.

Source files
------------

// File: rtl/audio_fetch_scheduler.sv
// Shares one single-port sample ROM between BGM and two SFX voices: one read per
// active channel on each sample tick, then a saturated signed mix of the samples.
module audio_fetch_scheduler #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BGM_BASE  = 0,
  parameter int unsigned BGM_LEN   = 176400,
  parameter int unsigned SFX0_BASE = 176400,
  parameter int unsigned SFX0_LEN  = 4410,
  parameter int unsigned SFX1_BASE = 180810,
  parameter int unsigned SFX1_LEN  = 4410
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              bgm_start,
  input  logic              bgm_stop,
  input  logic [1:0]        sfx_trig,
  input  logic              overrun_clr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [15:0]       mix_out,
  output logic              mix_valid,
  output logic              bgm_playing,
  output logic [ADDR_W-1:0] bgm_pos,
  output logic [1:0]        sfx_active,
  output logic              bgm_done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, MIX} state_t;

  // Channel index 0 = BGM, 1 = SFX0, 2 = SFX1 (also the issue priority order).
  localparam logic [ADDR_W-1:0] BASE [3] = '{ADDR_W'(BGM_BASE), ADDR_W'(SFX0_BASE), ADDR_W'(SFX1_BASE)};
  localparam logic [ADDR_W-1:0] LAST [3] = '{ADDR_W'(BGM_LEN - 1), ADDR_W'(SFX0_LEN - 1), ADDR_W'(SFX1_LEN - 1)};

  state_t                    state_q, state_d;
  logic [2:0]                act_q, act_d, mask_q, mask_d;
  logic [ADDR_W-1:0]         ptr_q [3];
  logic [ADDR_W-1:0]         ptr_d [3];
  logic signed [DATA_W-1:0]  smp_q [3];
  logic signed [DATA_W-1:0]  smp_d [3];
  logic                      pend_start_q, pend_start_d, pend_stop_q, pend_stop_d;
  logic [1:0]                pend_trig_q, pend_trig_d;
  logic                      rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic [1:0]                tag_q, tag_d, cap_tag_q, cap_tag_d;
  logic                      cap_v_q, cap_v_d;
  logic [15:0]               mix_q, mix_d;
  logic                      mix_valid_q, mix_valid_d;
  logic                      last_q, last_d, bgm_done_q, bgm_done_d;
  logic                      ovr_q, ovr_d;

  logic                      start_eff, stop_eff, iss_req;
  logic [1:0]                trig_eff, ch;
  logic [2:0]                iss_mask;
  logic signed [17:0]        sum;

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    smp_d        = smp_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    tag_d        = tag_q;
    cap_v_d      = rom_en_q;
    cap_tag_d    = tag_q;
    mix_d        = mix_q;
    mix_valid_d  = 1'b0;
    last_d       = 1'b0;
    bgm_done_d   = last_q;
    ovr_d        = ovr_q;
    iss_req      = 1'b0;
    iss_mask     = '0;
    ch           = '0;
    sum          = '0;

    // Later pulse overrides an older opposite request; same-cycle stop wins at apply.
    start_eff    = bgm_start | (pend_start_q & ~bgm_stop);
    stop_eff     = bgm_stop  | (pend_stop_q  & ~bgm_start);
    trig_eff     = pend_trig_q | sfx_trig;
    pend_start_d = start_eff;
    pend_stop_d  = stop_eff;
    pend_trig_d  = trig_eff;

    if (cap_v_q) smp_d[cap_tag_q] = rom_data;

    if (overrun_clr) ovr_d = 1'b0;
    if (sample_tick && state_q != IDLE) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        pend_start_d = 1'b0;
        pend_stop_d  = 1'b0;
        pend_trig_d  = '0;
        if (start_eff) begin
          act_d[0] = 1'b1;
          ptr_d[0] = '0;
        end
        if (stop_eff) act_d[0] = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
          if (trig_eff[i]) begin
            act_d[i+1] = 1'b1;
            ptr_d[i+1] = '0;
          end
        end
        // First issue happens on the tick edge itself so rom_en is high at T+1.
        if (sample_tick) begin
          for (int unsigned i = 0; i < 3; i++) begin
            if (!act_d[i]) smp_d[i] = '0;
          end
          iss_mask = act_d;
          iss_req  = |act_d;
          state_d  = (|act_d) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        iss_mask = mask_q;
        iss_req  = |mask_q;
        if (!(|mask_q)) state_d = DRAIN;
      end
      DRAIN: state_d = MIX;
      MIX: begin
        sum = 18'(smp_q[0]) + 18'(smp_q[1]) + 18'(smp_q[2]);
        if (sum > 18'sd32767)       mix_d = 16'h7FFF;
        else if (sum < -18'sd32768) mix_d = 16'h8000;
        else                        mix_d = sum[15:0];
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (iss_req) begin
      ch         = iss_mask[0] ? 2'd0 : (iss_mask[1] ? 2'd1 : 2'd2);
      rom_en_d   = 1'b1;
      rom_addr_d = BASE[ch] + ptr_d[ch];
      tag_d      = ch;
      mask_d     = iss_mask;
      mask_d[ch] = 1'b0;
      if (ptr_d[ch] == LAST[ch]) begin
        act_d[ch] = 1'b0;
        last_d    = (ch == 2'd0);
      end
      ptr_d[ch] = ptr_d[ch] + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_q        <= '0;
      mask_q       <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        ptr_q[i] <= '0;
        smp_q[i] <= '0;
      end
      pend_start_q <= 1'b0;
      pend_stop_q  <= 1'b0;
      pend_trig_q  <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      tag_q        <= '0;
      cap_v_q      <= 1'b0;
      cap_tag_q    <= '0;
      mix_q        <= '0;
      mix_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      bgm_done_q   <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      smp_q        <= smp_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      pend_trig_q  <= pend_trig_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      tag_q        <= tag_d;
      cap_v_q      <= cap_v_d;
      cap_tag_q    <= cap_tag_d;
      mix_q        <= mix_d;
      mix_valid_q  <= mix_valid_d;
      last_q       <= last_d;
      bgm_done_q   <= bgm_done_d;
      ovr_q        <= ovr_d;
    end
  end

  assign rom_en      = rom_en_q;
  assign rom_addr    = rom_addr_q;
  assign mix_out     = mix_q;
  assign mix_valid   = mix_valid_q;
  assign bgm_playing = act_q[0];
  assign bgm_pos     = ptr_q[0];
  assign sfx_active  = act_q[2:1];
  assign bgm_done    = bgm_done_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_audio_fetch_scheduler.sv
// Scoreboard bench for audio_fetch_scheduler: a frame-level model predicts ROM
// fetches, mixes and bgm_done pulses with their cycles; a monitor compares them.
module tb_audio_fetch_scheduler;

  localparam int AW        = 18;
  localparam int BGM_BASE  = 0;
  localparam int BGM_LEN   = 4;
  localparam int SFX0_BASE = 16;
  localparam int SFX0_LEN  = 8;
  localparam int SFX1_BASE = 32;
  localparam int SFX1_LEN  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0, bgm_start = 1'b0, bgm_stop = 1'b0, overrun_clr = 1'b0;
  logic [1:0]    sfx_trig = '0;
  logic          rom_en, mix_valid, bgm_playing, bgm_done, overrun;
  logic [AW-1:0] rom_addr, bgm_pos;
  logic [15:0]   rom_data = '0;
  logic [15:0]   mix_out;
  logic [1:0]    sfx_active;

  audio_fetch_scheduler #(
    .ADDR_W(AW), .DATA_W(16),
    .BGM_BASE(BGM_BASE), .BGM_LEN(BGM_LEN),
    .SFX0_BASE(SFX0_BASE), .SFX0_LEN(SFX0_LEN),
    .SFX1_BASE(SFX1_BASE), .SFX1_LEN(SFX1_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .bgm_start(bgm_start), .bgm_stop(bgm_stop), .sfx_trig(sfx_trig),
    .overrun_clr(overrun_clr), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .mix_out(mix_out), .mix_valid(mix_valid),
    .bgm_playing(bgm_playing), .bgm_pos(bgm_pos), .sfx_active(sfx_active),
    .bgm_done(bgm_done), .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] mem [64];
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr[5:0]];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  typedef struct {int unsigned cyc; int val;} exp_t;
  exp_t        addr_q[$];
  exp_t        mix_q[$];
  int unsigned done_q[$];

  // Behavioural model: channel activity, play positions, overrun flag, busy window.
  int          base_m [3] = '{BGM_BASE, SFX0_BASE, SFX1_BASE};
  int          len_m  [3] = '{BGM_LEN, SFX0_LEN, SFX1_LEN};
  bit          m_act  [3];
  int          m_ptr  [3];
  bit          m_ovr;
  int unsigned busy_until = 0;

  function automatic int sat16(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic model_frame(input int unsigned t);
    int n = 0;
    int sum = 0;
    int a;
    for (int c = 0; c < 3; c++) begin
      if (m_act[c]) begin
        n++;
        a = base_m[c] + m_ptr[c];
        addr_q.push_back('{cyc: t + n, val: a});
        sum += int'(mem[a]);
        m_ptr[c]++;
        if (m_ptr[c] == len_m[c]) begin
          m_act[c] = 1'b0;
          if (c == 0) done_q.push_back(t + n + 1);
        end
      end
    end
    mix_q.push_back('{cyc: t + n + 3, val: sat16(sum)});
    busy_until = t + n + 3;
  endtask

  task automatic drive(input bit tk, input bit st, input bit sp, input bit [1:0] tr, input bit clr);
    sample_tick = tk; bgm_start = st; bgm_stop = sp; sfx_trig = tr; overrun_clr = clr;
    if (clr) m_ovr = 1'b0;
    if (cyc < busy_until) begin
      if (tk) m_ovr = 1'b1;
    end else begin
      if (st) begin m_act[0] = 1'b1; m_ptr[0] = 0; end
      if (sp) m_act[0] = 1'b0;
      for (int v = 0; v < 2; v++)
        if (tr[v]) begin m_act[v+1] = 1'b1; m_ptr[v+1] = 0; end
      if (tk) model_frame(cyc);
    end
    @(posedge clk); #1;
    sample_tick = 1'b0; bgm_start = 1'b0; bgm_stop = 1'b0; sfx_trig = '0; overrun_clr = 1'b0;
  endtask

  task automatic check_status();
    chk("bgm_playing", int'(bgm_playing), int'(m_act[0]));
    chk("sfx_active", int'(sfx_active), int'({m_act[2], m_act[1]}));
    chk("bgm_pos", int'(bgm_pos), m_ptr[0]);
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) drive(0, 0, 0, 2'b00, 0);
    check_status();
  endtask

  // Monitor: every cycle, each event must occur exactly when the scoreboard says.
  always @(negedge clk) if (rst_n) begin
    bit e;
    exp_t x;
    while (addr_q.size() > 0 && addr_q[0].cyc < cyc) void'(addr_q.pop_front());
    while (mix_q.size() > 0 && mix_q[0].cyc < cyc) void'(mix_q.pop_front());
    while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
    e = (addr_q.size() > 0) && (addr_q[0].cyc == cyc);
    chk("rom_en", int'(rom_en), int'(e));
    if (e) begin
      x = addr_q.pop_front();
      chk("rom_addr", int'(rom_addr), x.val);
    end
    e = (mix_q.size() > 0) && (mix_q[0].cyc == cyc);
    chk("mix_valid", int'(mix_valid), int'(e));
    if (e) begin
      x = mix_q.pop_front();
      chk("mix_out", int'($signed(mix_out)), x.val);
    end
    e = (done_q.size() > 0) && (done_q[0] == cyc);
    chk("bgm_done", int'(bgm_done), int'(e));
    if (e) void'(done_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 16'(i);
    for (int c = 0; c < 3; c++) begin m_act[c] = 1'b0; m_ptr[c] = 0; end
    m_ovr = 1'b0;

    // Reset
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rom_en", int'(rom_en), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_bgm_done", int'(bgm_done), 0);
    check_status();

    // Idle tick: no fetch, zero mix at T+3
    drive(1, 0, 0, 2'b00, 0);
    wait_idle();

    // BGM end of playback: data = address, ticks every 10 cycles
    drive(0, 1, 0, 2'b00, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 2'b00, 0);
      repeat (9) drive(0, 0, 0, 2'b00, 0);
      check_status();
    end
    chk("bgm_ended", int'(bgm_playing), 0);

    // Saturation
    mem[BGM_BASE] = 16'sd30000; mem[SFX0_BASE] = 16'sd30000;
    drive(1, 1, 0, 2'b01, 0);
    wait_idle();
    mem[BGM_BASE] = -16'sd30000; mem[SFX0_BASE] = -16'sd30000;
    drive(1, 1, 0, 2'b01, 0);
    wait_idle();
    mem[BGM_BASE] = 16'sd100; mem[SFX0_BASE] = -16'sd300; mem[SFX1_BASE] = 16'sd50;
    drive(1, 1, 0, 2'b11, 0);
    wait_idle();

    // Overrun with two channels active
    drive(0, 0, 1, 2'b00, 0);
    drive(1, 0, 0, 2'b00, 0);
    drive(0, 0, 0, 2'b00, 0);
    drive(1, 0, 0, 2'b00, 0);
    wait_idle();
    chk("overrun_set", int'(overrun), 1);
    drive(0, 0, 0, 2'b00, 1);
    chk("overrun_clr", int'(overrun), 0);

    // SFX0 restart at pointer 5 coinciding with a tick
    drive(0, 0, 0, 2'b01, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 2'b00, 0);
      wait_idle();
    end
    chk("sfx0_pos5", m_ptr[1], 5);
    drive(1, 0, 0, 2'b01, 0);
    wait_idle();

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      bit idle, tk, st, sp, clr;
      bit [1:0] tr;
      idle = (cyc >= busy_until);
      if (idle && $urandom_range(0, 3) == 0)
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
      tk  = ($urandom_range(0, 4) == 0);
      st  = idle && ($urandom_range(0, 7) == 0);
      sp  = idle && ($urandom_range(0, 11) == 0);
      tr  = idle ? 2'($urandom_range(0, 3) & $urandom_range(0, 3) & $urandom_range(0, 3)) : 2'b00;
      clr = ($urandom_range(0, 15) == 0);
      drive(tk, st, sp, tr, clr);
      if (cyc >= busy_until) check_status();
    end
    wait_idle();

    // Asynchronous reset in the middle of ISSUE
    drive(1, 1, 0, 2'b11, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rom_en", int'(rom_en), 0);
    addr_q.delete(); mix_q.delete(); done_q.delete();
    for (int c = 0; c < 3; c++) begin m_act[c] = 1'b0; m_ptr[c] = 0; end
    m_ovr = 1'b0;
    busy_until = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_mix_out", int'(mix_out), 0);
    check_status();
    repeat (10) drive(0, 0, 0, 2'b00, 0);

    chk("addr_q_empty", addr_q.size(), 0);
    chk("mix_q_empty", mix_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
